// File: rtl/aibnd_preclkdiv_nch.sv
// Multi-channel pre-clock divider: NCH independent clkin dividers with enable/ack handshake.
// Latency: clkout/ch_ack are registered; first high phase appears 1 cycle after ch_en is sampled.
// Backpressure: none; a disabled channel drains its current period before going idle.
module aibnd_preclkdiv_nch #(
  parameter int NCH  = 4,
  parameter int DIVW = 4
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH-1:0]      ch_inv,
  input  logic [NCH*DIVW-1:0] ch_ratio,
  input  logic                sync,
  output logic [NCH-1:0]      clkout,
  output logic [NCH-1:0]      ch_ack,
  inout  wire                 vccl,
  inout  wire                 vssl
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } st_t;

  st_t            st_q    [NCH];
  st_t            st_d    [NCH];
  logic [DIVW-1:0] cnt_q   [NCH];
  logic [DIVW-1:0] cnt_d   [NCH];
  logic [DIVW-1:0] ratio_q [NCH];
  logic [DIVW-1:0] ratio_d [NCH];
  logic [DIVW-1:0] rat     [NCH];
  logic [NCH-1:0]  phase_q, phase_d;
  logic [NCH-1:0]  inv_q, inv_d;
  logic [NCH-1:0]  ack_d, clk_d;
  logic [NCH-1:0]  wrap, bnd;

  // Supply pins carry no logic; fold them into a sink so they are not flagged as dangling.
  wire unused_supply = vccl ^ vssl;

  // Per-channel ratio slice and half-period / full-period end detection.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign rat[g]  = ch_ratio[g*DIVW +: DIVW];
    assign wrap[g] = (cnt_q[g] == ratio_q[g]);
    assign bnd[g]  = wrap[g] && !phase_q[g];
  end

  // Next-state and next-output logic for every channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      ratio_d[i] = ratio_q[i];
      phase_d[i] = phase_q[i];
      inv_d[i]   = inv_q[i];
      ack_d[i]   = 1'b0;
      case (st_q[i])
        OFF: begin
          phase_d[i] = 1'b0;
          cnt_d[i]   = '0;
          if (ch_en[i]) begin
            st_d[i]    = RUN;
            ratio_d[i] = rat[i];
            inv_d[i]   = ch_inv[i];
            phase_d[i] = 1'b1;
            ack_d[i]   = 1'b1;
          end
        end
        RUN, DRAIN: begin
          ack_d[i] = 1'b1;
          if (sync) begin
            // Alignment restart: may truncate the current period.
            cnt_d[i]   = '0;
            phase_d[i] = 1'b1;
            ratio_d[i] = rat[i];
            st_d[i]    = ch_en[i] ? RUN : DRAIN;
          end else begin
            if (wrap[i]) begin
              cnt_d[i]   = '0;
              phase_d[i] = ~phase_q[i];
            end else begin
              cnt_d[i] = DIVW'(cnt_q[i] + 1'b1);
            end
            // New ratio only takes effect on a full-period boundary.
            if (bnd[i]) ratio_d[i] = rat[i];
            if (ch_en[i]) begin
              st_d[i] = RUN;
            end else if (st_q[i] == DRAIN && bnd[i]) begin
              st_d[i]    = OFF;
              phase_d[i] = 1'b0;
              ack_d[i]   = 1'b0;
            end else begin
              st_d[i] = DRAIN;
            end
          end
        end
        default: begin
          st_d[i]    = OFF;
          phase_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end
      endcase
      clk_d[i] = phase_d[i] ^ inv_d[i];
    end
  end

  // State, counters and registered outputs; reset idles every channel low.
  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= OFF;
        cnt_q[i]   <= '0;
        ratio_q[i] <= '0;
      end
      phase_q <= '0;
      inv_q   <= '0;
      clkout  <= '0;
      ch_ack  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= st_d[i];
        cnt_q[i]   <= cnt_d[i];
        ratio_q[i] <= ratio_d[i];
      end
      phase_q <= phase_d;
      inv_q   <= inv_d;
      clkout  <= clk_d;
      ch_ack  <= ack_d;
    end
  end

endmodule
